// File: rtl/spart_driver_pkg.sv
// Shared definitions for the SPART bus master: register addresses, read/write
// encodings, baud table, FSM states and the baud divisor helper.
package spart_driver_pkg;

    typedef enum logic [1:0] {
        CFG_LO = 2'b00,
        CFG_HI = 2'b01,
        GAP    = 2'b10,
        RUN    = 2'b11
    } drv_state_t;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam logic IO_RD = 1'b1;
    localparam logic IO_WR = 1'b0;

    localparam int BAUD_4800  = 4800;
    localparam int BAUD_9600  = 9600;
    localparam int BAUD_19200 = 19200;
    localparam int BAUD_38400 = 38400;

    // Divisor for the 16x oversampling baud generator, truncating division.
    function automatic logic [15:0] baud_div(input logic [1:0] sel, input int clk_freq);
        int baud;
        baud = BAUD_4800;
        case (sel)
            2'b00: baud = BAUD_4800;
            2'b01: baud = BAUD_9600;
            2'b10: baud = BAUD_19200;
            2'b11: baud = BAUD_38400;
            default: baud = BAUD_4800;
        endcase
        return 16'(clk_freq / (16 * baud) - 1);
    endfunction

endpackage

// File: rtl/spart_driver_if.sv
// SPART register bus. A transaction is exactly one cycle with iocs high; there is
// no ready/wait: the SPART completes every access within that cycle.
interface spart_driver_if;
    import spart_driver_pkg::*;

    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    drv_state_t state;

    modport master (input rda, tbr, output iocs, iorw, ioaddr, state, inout databus);
    modport slave  (output rda, tbr, input iocs, iorw, ioaddr, state, inout databus);
endinterface

// File: rtl/spart_drv_fifo.sv
// Echo buffer: a circular FIFO for DEPTH >= 2, or a single holding register with
// a valid bit when DEPTH == 1.
module spart_drv_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    if (DEPTH == 1) begin : g_reg
        logic [7:0] hold_q;
        logic       vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else begin
                if (pop) vld_q <= 1'b0;
                if (push) vld_q <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push) hold_q <= din;
        end

        assign full  = vld_q;
        assign empty = !vld_q;
        assign head  = hold_q;
    end else begin : g_ring
        localparam int AW = $clog2(DEPTH);

        // Extra pointer MSB distinguishes full from empty when the indices match.
        logic [AW:0]  wr_ptr;
        logic [AW:0]  rd_ptr;
        logic [7:0]   mem [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push && !full) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
                if (pop && !empty) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end

        always_ff @(posedge clk) begin
            if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
        end

        assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign empty = (wr_ptr == rd_ptr);
        assign head  = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes rx bytes to tx.
// Define DRV_FIFO_EN for a FIFO_DEPTH echo FIFO; otherwise a single holding register.
module spart_driver
    import spart_driver_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            br_cfg,
    output logic                  cfg_done,
    spart_driver_if.master        bus
);

`ifdef DRV_FIFO_EN
    localparam int BUF_DEPTH = FIFO_DEPTH;
`else
    // FIFO_DEPTH has no effect in this build; the buffer is one entry.
    localparam int BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

    drv_state_t state;
    logic [1:0] cfg_q;
    logic       iocs_q;
    logic       iorw_q;
    logic [1:0] ioaddr_q;
    logic [7:0] dout_q;

    logic [15:0] div_new;
    logic [15:0] div_cur;
    logic        buf_full;
    logic        buf_empty;
    logic [7:0]  buf_head;
    logic        buf_push;
    logic        cfg_match;
    logic        rd_go;
    logic        wr_go;

    assign div_new = baud_div(br_cfg, CLK_FREQ);
    assign div_cur = baud_div(cfg_q, CLK_FREQ);

    // Read data is on the bus during the read cycle; capture it at the edge ending it.
    assign buf_push  = (state == GAP) && iocs_q && (iorw_q == IO_RD);
    assign cfg_match = (br_cfg == cfg_q);
    assign rd_go     = (state == RUN) && cfg_match && bus.rda && !buf_full;
    assign wr_go     = (state == RUN) && cfg_match && !rd_go && bus.tbr && !buf_empty;

    spart_drv_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (wr_go),
        .din   (bus.databus),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (buf_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CFG_LO;
            cfg_q    <= 2'b00;
            iocs_q   <= 1'b0;
            iorw_q   <= IO_RD;
            ioaddr_q <= ADDR_BUF;
            dout_q   <= 8'h00;
            cfg_done <= 1'b0;
        end else begin
            iocs_q   <= 1'b0;
            iorw_q   <= IO_RD;
            ioaddr_q <= ADDR_BUF;
            case (state)
                CFG_LO: begin
                    cfg_q    <= br_cfg;
                    iocs_q   <= 1'b1;
                    iorw_q   <= IO_WR;
                    ioaddr_q <= ADDR_DBL;
                    dout_q   <= div_new[7:0];
                    cfg_done <= 1'b0;
                    state    <= CFG_HI;
                end
                CFG_HI: begin
                    iocs_q   <= 1'b1;
                    iorw_q   <= IO_WR;
                    ioaddr_q <= ADDR_DBH;
                    dout_q   <= div_cur[15:8];
                    state    <= GAP;
                end
                GAP: begin
                    cfg_done <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (!cfg_match) begin
                        cfg_done <= 1'b0;
                        state    <= CFG_LO;
                    end else if (rd_go) begin
                        iocs_q <= 1'b1;
                        state  <= GAP;
                    end else if (wr_go) begin
                        iocs_q <= 1'b1;
                        iorw_q <= IO_WR;
                        dout_q <= buf_head;
                        state  <= GAP;
                    end
                end
                default: state <= CFG_LO;
            endcase
        end
    end

    assign bus.iocs    = iocs_q;
    assign bus.iorw    = iorw_q;
    assign bus.ioaddr  = ioaddr_q;
    assign bus.state   = state;
    assign bus.databus = (iocs_q && (iorw_q == IO_WR)) ? dout_q : 8'hzz;

endmodule
